// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong scoring path: FSM states, BCD digit
// types and a two-digit BCD incrementer.
package pong_pkg;

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        LOCKOUT = 2'd1,
        OVER    = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd2_t;

    // Tens never wrap: the game ends at WIN_SCORE <= 99.
    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        bcd_digit_t ones;
        bcd_digit_t tens;
        ones = v[3:0];
        tens = v[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Bundle of the scoring strobes from the ball block and the score/win
// outputs returned to the ball, display and sound blocks.
interface score_keeper_if;
    import pong_pkg::*;

    logic  player_Scored;
    logic  cpu_Scored;
    logic  start;
    bcd2_t player_Score_BCD;
    bcd2_t cpu_Score_BCD;
    logic  player_Win;
    logic  cpu_Win;
    logic  point_Pulse;

    modport master (
        output player_Scored, cpu_Scored, start,
        input  player_Score_BCD, cpu_Score_BCD, player_Win, cpu_Win, point_Pulse
    );

    modport slave (
        input  player_Scored, cpu_Scored, start,
        output player_Score_BCD, cpu_Score_BCD, player_Win, cpu_Win, point_Pulse
    );

endinterface

// File: rtl/bcd_score_counter.sv
// One side's score, held both as a 7-bit binary count (for the win compare)
// and as two BCD digits (for the display).
module bcd_score_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [6:0] count,
    output bcd2_t      bcd
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 7'd0;
            bcd   <= 8'h00;
        end else if (inc) begin
            count <= count + 7'd1;
            bcd   <= bcd2_inc(bcd);
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Scoring FSM: edge-detects the scored levels, counts points, enforces a
// post-point lockout and latches the winner until a new game is started.
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = 7,
    parameter int LOCKOUT_CYCLES = 2097152
) (
    input logic           clk,
    input logic           rst,
    score_keeper_if.slave bus
);

    localparam int               CNT_W     = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [6:0]       WIN_PREV  = 7'(WIN_SCORE - 1);

    state_t           state;
    state_t           state_nxt;
    logic             player_prev;
    logic             cpu_prev;
    logic             player_ev;
    logic             cpu_ev;
    logic [CNT_W-1:0] lock_cnt;
    logic [6:0]       player_count;
    logic [6:0]       cpu_count;
    bcd2_t            player_bcd;
    bcd2_t            cpu_bcd;
    logic             player_inc;
    logic             cpu_inc;
    logic             score_clr;
    logic             lock_load;
    logic             player_win_set;
    logic             cpu_win_set;
    logic             point_pulse;
    logic             player_win;
    logic             cpu_win;

    assign player_ev = bus.player_Scored & ~player_prev;
    assign cpu_ev    = bus.cpu_Scored & ~cpu_prev;

    always_ff @(posedge clk) begin
        if (rst) state <= PLAY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            PLAY: begin
                // Simultaneous events cancel out and leave the game in PLAY.
                if (player_ev ^ cpu_ev)
                    state_nxt = ((player_ev ? player_count : cpu_count) == WIN_PREV) ? OVER : LOCKOUT;
            end
            LOCKOUT: if (lock_cnt == '0) state_nxt = PLAY;
            OVER:    if (bus.start) state_nxt = LOCKOUT;
            default: state_nxt = PLAY;
        endcase
    end

    always_comb begin
        player_inc     = 1'b0;
        cpu_inc        = 1'b0;
        score_clr      = 1'b0;
        lock_load      = 1'b0;
        player_win_set = 1'b0;
        cpu_win_set    = 1'b0;
        case (state)
            PLAY: begin
                player_inc     = player_ev & ~cpu_ev;
                cpu_inc        = cpu_ev & ~player_ev;
                player_win_set = player_inc && (player_count == WIN_PREV);
                cpu_win_set    = cpu_inc && (cpu_count == WIN_PREV);
                lock_load      = (player_inc & ~player_win_set) | (cpu_inc & ~cpu_win_set);
            end
            OVER: begin
                score_clr = bus.start;
                lock_load = bus.start;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            player_prev <= 1'b0;
            cpu_prev    <= 1'b0;
            lock_cnt    <= '0;
            point_pulse <= 1'b0;
            player_win  <= 1'b0;
            cpu_win     <= 1'b0;
        end else begin
            player_prev <= bus.player_Scored;
            cpu_prev    <= bus.cpu_Scored;
            point_pulse <= player_inc | cpu_inc;
            if (lock_load)
                lock_cnt <= LOCK_LOAD;
            else if (state == LOCKOUT && lock_cnt != '0)
                lock_cnt <= lock_cnt - CNT_W'(1);
            if (score_clr) begin
                player_win <= 1'b0;
                cpu_win    <= 1'b0;
            end else begin
                if (player_win_set) player_win <= 1'b1;
                if (cpu_win_set)    cpu_win    <= 1'b1;
            end
        end
    end

    bcd_score_counter u_player (
        .clk   (clk),
        .rst   (rst),
        .clr   (score_clr),
        .inc   (player_inc),
        .count (player_count),
        .bcd   (player_bcd)
    );

    bcd_score_counter u_cpu (
        .clk   (clk),
        .rst   (rst),
        .clr   (score_clr),
        .inc   (cpu_inc),
        .count (cpu_count),
        .bcd   (cpu_bcd)
    );

    assign bus.player_Score_BCD = player_bcd;
    assign bus.cpu_Score_BCD    = cpu_bcd;
    assign bus.player_Win       = player_win;
    assign bus.cpu_Win          = cpu_win;
    assign bus.point_Pulse      = point_pulse;

endmodule
